// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over a req/resp handshake
// and holds the registered instruction until the consumer accepts it. Option: FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    // instruction memory
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    // decode-side handshake
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            misalign_fault,
`endif
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target
);

    localparam logic [31:0] Nop = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StFault} state_e;
`else
    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;
`endif

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic            imem_req_q;
    logic            instr_valid_q;
    logic [XLEN-1:0] pc_plus4_w;
    logic [XLEN-1:0] sel_pc;
    logic [XLEN-1:0] next_pc;

    assign pc_plus4_w = pc_q + XLEN'(32'd4);
    assign sel_pc     = redirect ? redirect_target : pc_plus4_w;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q;
    logic misaligned;

    // A misaligned target is kept verbatim so the trap handler can see it.
    assign next_pc        = sel_pc;
    assign misaligned     = |sel_pc[1:0];
    assign misalign_fault = fault_q;
`else
    assign next_pc = sel_pc & ~XLEN'(32'd3);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            instr_q       <= Nop;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q    <= StReq;
                    imem_req_q <= 1'b1;
                end
                StReq: begin
                    if (imem_ready) begin
                        imem_req_q <= 1'b0;
                        if (imem_rvalid) begin
                            instr_q       <= imem_rdata;
                            instr_valid_q <= 1'b1;
                            state_q       <= StHold;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (imem_rvalid) begin
                        instr_q       <= imem_rdata;
                        instr_valid_q <= 1'b1;
                        state_q       <= StHold;
                    end
                end
                StHold: begin
                    // instr_valid is high throughout HOLD, so instr_ready alone is the handshake.
                    if (instr_ready) begin
                        instr_valid_q <= 1'b0;
                        pc_q          <= next_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            fault_q <= 1'b1;
                            state_q <= StFault;
                        end else begin
                            imem_req_q <= 1'b1;
                            state_q    <= StReq;
                        end
`else
                        imem_req_q <= 1'b1;
                        state_q    <= StReq;
`endif
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                StFault: begin
                    state_q <= StFault;
                end
`endif
                default: begin
                    state_q       <= StIdle;
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign op          = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7      = instr_q[31:25];
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_w;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the RISC-Duo core. It sits directly upstream of the controller and datapath. It owns the program counter, issues word reads to instruction memory over a request/response handshake, and registers the returned instruction. It presents the instruction with its `op`/`funct3`/`funct7` fields and a valid/ready handshake. On each accepted instruction it advances to PC+4 or to a redirect target supplied by the datapath.

## Interface
- `XLEN`, 32: address/PC width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  XLEN  request address, equals `pc`.
- `imem_ready`  in  1  memory accepts request this cycle.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  registered instruction available.
- `instr_ready`  in  1  consumer accepts instruction.
- `instr`  out  32  registered instruction.
- `op`  out  opcode_e  `instr[6:0]`.
- `funct3`  out  funct3_e  `instr[14:12]`.
- `funct7`  out  funct7_e  `instr[31:25]`.
- `pc`  out  XLEN  address of `instr`.
- `pc_plus4`  out  XLEN  `pc + 4`, modulo 2^XLEN.
- `redirect`  in  1  taken branch/jump for the instruction being accepted.
- `redirect_target`  in  XLEN  next PC when `redirect`.
- `misalign_fault`  out  1  present only with `FETCH_MISALIGN_TRAP_EN`.

## Operation
- States: IDLE, REQ, WAIT, HOLD, plus FAULT under the macro.
- **IDLE** (entered on reset): all outputs deasserted. The next cycle goes to REQ.
- **REQ**: `imem_req`=1 and `imem_addr`=`pc`, both held until `imem_ready`.
  - `imem_ready` & `imem_rvalid` in the same cycle: capture `imem_rdata`, go to HOLD.
  - `imem_ready` only: go to WAIT.
- **WAIT**: `imem_req`=0. On `imem_rvalid`, capture `imem_rdata` and go to HOLD.
- **HOLD**: `instr_valid`=1.
  - `instr`, fields and `pc` stay stable until the handshake (`instr_valid & instr_ready`).
  - On the handshake: `pc <= redirect ? redirect_target : pc + 4`, go to REQ.
- `redirect` is sampled only on the handshake cycle and ignored otherwise.
- `imem_rvalid` is ignored in IDLE, REQ-without-ready, and HOLD.
- PC arithmetic wraps modulo 2^XLEN.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `instr`=32'h0000_0013 (NOP), fields derived from that NOP.
  - `instr_valid`=0, `imem_req`=0, `misalign_fault`=0.
- Reset asserted mid-operation: immediate return to IDLE. Any outstanding memory response is dropped.
- Zero-wait memory timing, counted from the first edge after reset deassert:
  - cycle 0: IDLE.
  - cycle 1: REQ.
  - cycle 2: `instr_valid`=1.
- Sustained throughput: one instruction per 2 cycles (REQ, HOLD) with zero-wait memory and `instr_ready` held high.
- Each additional memory wait cycle, and each cycle `instr_ready` is low, adds exactly one cycle.
- Outputs are registered. There is no combinational path from `instr_ready`/`redirect` to `instr*`.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - If the next PC selected on a handshake has `[1:0]`≠0, go to FAULT.
  - FAULT: `misalign_fault`=1 (sticky), `imem_req`=0, `instr_valid`=0; exit only on reset.
  - `pc` holds the faulting target.
- Not defined:
  - `misalign_fault` port is absent and there is no FAULT state.
  - The next PC has bits `[1:0]` forced to 0.

## Test plan
- Reset, zero-wait memory returning 32'h00500093, `instr_ready`=1 -> `instr_valid` at cycle 2, `pc`=0, `op`=7'h13, `funct3`=0, `funct7`=0; next `imem_addr`=4.
- Memory stalls `imem_ready` 2 cycles, then `rvalid` 3 cycles later -> `imem_addr` stable throughout, one capture, `instr_valid` rises exactly once.
- `instr_ready` low 4 cycles in HOLD while `imem_rdata` toggles -> `instr`/`pc` unchanged, no new `imem_req` issued.
- Handshake with `redirect`=1, target 32'h100 -> next `imem_addr`=32'h100, `pc_plus4`=32'h104 once it is issued. `redirect`=1 outside a handshake -> ignored.
- `pc`=32'hFFFF_FFFC, handshake without redirect -> next `pc`=0. Reset asserted during WAIT, then late `rvalid` -> dropped, fetch restarts at `RESET_PC`.
- Macro on, redirect target 32'h102 -> `misalign_fault`=1 from the next cycle, no `imem_req` afterwards. Macro off -> fetch from 32'h100.
